// File: rtl/yolo_hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS instance: merges stream and child-monitor block flags,
// filters them by a persistence threshold and latches a sticky flag with source snapshot.
module yolo_hls_deadlock_monitor_param #(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_SUB  = 1,
  parameter int unsigned THRESH = 16,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned SUB_W = (N_SUB > 0) ? N_SUB : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_AXIS-1:0]       axis_block_sigs,
  input  logic [SUB_W-1:0]        sub_block_sigs,
  input  logic [SUB_W-1:0]        sub_idle_sigs,
  input  logic                    clear,
  output logic                    block_raw,
  output logic                    block,
  output logic [N_AXIS+SUB_W-1:0] block_src,
  output logic [CNT_W-1:0]        block_cycles
);

  typedef enum logic [1:0] {StIdle, StArmed, StDetected} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_AXIS+SUB_W-1:0] src_q, src_d;
  logic                    raw_q;

  logic                    axis_any, sub_all, blk;
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W:0]          cnt_plus;

  assign axis_any = |axis_block_sigs;

  // A sub path is blocked only when every child is stuck or idle and at least one is stuck.
  if (N_SUB > 0) begin : g_sub
    assign sub_all = (&(sub_block_sigs | sub_idle_sigs)) & (|sub_block_sigs);
  end else begin : g_no_sub
    logic unused_sub;
    assign unused_sub = ^{sub_block_sigs, sub_idle_sigs};
    assign sub_all    = 1'b0;
  end

  assign blk      = axis_any | sub_all;
  assign cnt_plus = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_plus[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      src_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (blk) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            if (THRESH == 1) begin
              state_d = StDetected;
              src_d   = {sub_block_sigs, axis_block_sigs};
            end else begin
              state_d = StArmed;
            end
          end else begin
            cnt_d = '0;
          end
        end
        StArmed: begin
          if (blk) begin
            cnt_d = cnt_inc;
            if (cnt_plus == (CNT_W+1)'(THRESH)) begin
              state_d = StDetected;
              src_d   = {sub_block_sigs, axis_block_sigs};
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StDetected: begin
          if (blk) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          src_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      src_q   <= '0;
      raw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      raw_q   <= blk;
    end
  end

  assign block_raw    = raw_q;
  assign block        = (state_q == StDetected);
  assign block_src    = src_q;
  assign block_cycles = cnt_q;

endmodule

// File: tb/tb_yolo_hls_deadlock_monitor_param.sv
// Directed bench for the deadlock monitor; four instances cover threshold, sub-path,
// saturation and single-cycle-threshold configurations.
module tb_yolo_hls_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset, clear;
  logic [1:0] axis;
  logic       sub_blk_a, sub_idle_a;
  logic [1:0] sub_blk_b, sub_idle_b;

  logic       raw_a, blk_a, raw_b, blk_b, raw_c, blk_c, raw_d, blk_d;
  logic [2:0] src_a, src_c, src_d;
  logic [3:0] src_b;
  logic [7:0] cyc_a, cyc_b, cyc_d;
  logic [2:0] cyc_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  yolo_hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(1), .THRESH(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .sub_block_sigs(sub_blk_a),
    .sub_idle_sigs(sub_idle_a), .clear(clear), .block_raw(raw_a), .block(blk_a),
    .block_src(src_a), .block_cycles(cyc_a));

  yolo_hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(2), .THRESH(4), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(2'b00), .sub_block_sigs(sub_blk_b),
    .sub_idle_sigs(sub_idle_b), .clear(clear), .block_raw(raw_b), .block(blk_b),
    .block_src(src_b), .block_cycles(cyc_b));

  yolo_hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(1), .THRESH(2), .CNT_W(3)) dut_c (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .sub_block_sigs(sub_blk_a),
    .sub_idle_sigs(sub_idle_a), .clear(clear), .block_raw(raw_c), .block(blk_c),
    .block_src(src_c), .block_cycles(cyc_c));

  yolo_hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(1), .THRESH(1), .CNT_W(8)) dut_d (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .sub_block_sigs(sub_blk_a),
    .sub_idle_sigs(sub_idle_a), .clear(clear), .block_raw(raw_d), .block(blk_d),
    .block_src(src_d), .block_cycles(cyc_d));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; axis = 2'b00;
    sub_blk_a = 1'b0; sub_idle_a = 1'b0; sub_blk_b = 2'b00; sub_idle_b = 2'b00;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({raw_a, blk_a, src_a, cyc_a} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_state got raw=%b blk=%b src=%b cyc=%0d want all zero",
               raw_a, blk_a, src_a, cyc_a);
    end
  endtask

  task automatic test_persist();
    do_reset();
    axis = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      vectors++;
      if (raw_a !== 1'b1) begin
        miscompares++; $display("FAIL persist_raw[%0d] got %b want 1", i, raw_a);
      end
      vectors++;
      if (blk_a !== (i >= 4)) begin
        miscompares++; $display("FAIL persist_block[%0d] got %b want %b", i, blk_a, i >= 4);
      end
      vectors++;
      if (cyc_a !== 8'(i)) begin
        miscompares++; $display("FAIL persist_cycles[%0d] got %0d want %0d", i, cyc_a, i);
      end
      vectors++;
      if (src_a !== ((i >= 4) ? 3'b001 : 3'b000)) begin
        miscompares++; $display("FAIL persist_src[%0d] got %b want %b", i, src_a,
                                (i >= 4) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_gap();
    logic       pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    logic [7:0] exp_cyc[8] = '{1, 2, 3, 0, 1, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      axis = pat[i] ? 2'b01 : 2'b00;
      step();
      vectors++;
      if (cyc_a !== exp_cyc[i]) begin
        miscompares++; $display("FAIL gap_cycles[%0d] got %0d want %0d", i, cyc_a, exp_cyc[i]);
      end
      vectors++;
      if (blk_a !== (i == 7)) begin
        miscompares++; $display("FAIL gap_block[%0d] got %b want %b", i, blk_a, i == 7);
      end
      vectors++;
      if (raw_a !== pat[i]) begin
        miscompares++; $display("FAIL gap_raw[%0d] got %b want %b", i, raw_a, pat[i]);
      end
    end
  endtask

  task automatic test_sub();
    do_reset();
    sub_blk_b = 2'b01; sub_idle_b = 2'b10;
    sub_blk_a = 1'b1;
    step();
    vectors++;
    if (raw_b !== 1'b1) begin
      miscompares++; $display("FAIL sub_raw got %b want 1", raw_b);
    end
    vectors++;
    if (raw_a !== 1'b1) begin
      miscompares++; $display("FAIL sub_single_raw got %b want 1", raw_a);
    end
    repeat (3) step();
    vectors++;
    if (blk_b !== 1'b1 || src_b !== 4'b0100) begin
      miscompares++; $display("FAIL sub_detect got blk=%b src=%b want blk=1 src=0100", blk_b, src_b);
    end
    do_reset();
    sub_blk_b = 2'b01; sub_idle_b = 2'b00;
    repeat (6) step();
    vectors++;
    if (raw_b !== 1'b0 || blk_b !== 1'b0 || cyc_b !== 8'd0) begin
      miscompares++; $display("FAIL sub_not_idle got raw=%b blk=%b cyc=%0d want 0 0 0",
                              raw_b, blk_b, cyc_b);
    end
    sub_blk_b = 2'b00; sub_idle_b = 2'b11;
    repeat (6) step();
    vectors++;
    if (raw_b !== 1'b0 || blk_b !== 1'b0 || cyc_b !== 8'd0) begin
      miscompares++; $display("FAIL sub_all_idle got raw=%b blk=%b cyc=%0d want 0 0 0",
                              raw_b, blk_b, cyc_b);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    axis = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      step();
      vectors++;
      if (cyc_c !== 3'((i > 7) ? 7 : i)) begin
        miscompares++; $display("FAIL sat_cycles[%0d] got %0d want %0d", i, cyc_c, (i > 7) ? 7 : i);
      end
      vectors++;
      if (blk_c !== (i >= 2)) begin
        miscompares++; $display("FAIL sat_block[%0d] got %b want %b", i, blk_c, i >= 2);
      end
    end
    axis = 2'b01; sub_blk_a = 1'b1;
    step();
    vectors++;
    if (src_c !== 3'b010 || blk_c !== 1'b1 || cyc_c !== 3'd7) begin
      miscompares++; $display("FAIL sat_hold got src=%b blk=%b cyc=%0d want 010 1 7",
                              src_c, blk_c, cyc_c);
    end
    axis = 2'b00; sub_blk_a = 1'b0;
    step();
    vectors++;
    if (blk_c !== 1'b1 || raw_c !== 1'b0 || cyc_c !== 3'd7) begin
      miscompares++; $display("FAIL sat_sticky got blk=%b raw=%b cyc=%0d want 1 0 7",
                              blk_c, raw_c, cyc_c);
    end
  endtask

  task automatic test_clear();
    do_reset();
    axis = 2'b01;
    repeat (5) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if (blk_a !== 1'b0 || src_a !== 3'b000 || cyc_a !== 8'd0 || raw_a !== 1'b1) begin
      miscompares++; $display("FAIL clear_detected got blk=%b src=%b cyc=%0d raw=%b want 0 000 0 1",
                              blk_a, src_a, cyc_a, raw_a);
    end
    repeat (3) step();
    vectors++;
    if (blk_a !== 1'b0 || cyc_a !== 8'd3) begin
      miscompares++; $display("FAIL clear_rearm got blk=%b cyc=%0d want 0 3", blk_a, cyc_a);
    end
    step();
    vectors++;
    if (blk_a !== 1'b1 || cyc_a !== 8'd4 || src_a !== 3'b001) begin
      miscompares++; $display("FAIL clear_redetect got blk=%b cyc=%0d src=%b want 1 4 001",
                              blk_a, cyc_a, src_a);
    end
    do_reset();
    axis = 2'b01;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if (blk_a !== 1'b0 || cyc_a !== 8'd0 || src_a !== 3'b000) begin
      miscompares++; $display("FAIL clear_entry_edge got blk=%b cyc=%0d src=%b want 0 0 000",
                              blk_a, cyc_a, src_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    axis = 2'b01;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({raw_a, blk_a, src_a, cyc_a} !== 13'd0) begin
      miscompares++; $display("FAIL reset_armed got raw=%b blk=%b src=%b cyc=%0d want all zero",
                              raw_a, blk_a, src_a, cyc_a);
    end
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({raw_a, blk_a, src_a, cyc_a} !== 13'd0) begin
      miscompares++; $display("FAIL reset_detected got raw=%b blk=%b src=%b cyc=%0d want all zero",
                              raw_a, blk_a, src_a, cyc_a);
    end
  endtask

  task automatic test_thresh1();
    do_reset();
    step();
    vectors++;
    if (blk_d !== 1'b0) begin
      miscompares++; $display("FAIL t1_idle got %b want 0", blk_d);
    end
    axis = 2'b01;
    step();
    axis = 2'b00;
    vectors++;
    if (blk_d !== 1'b1 || cyc_d !== 8'd1 || src_d !== 3'b001) begin
      miscompares++; $display("FAIL t1_detect got blk=%b cyc=%0d src=%b want 1 1 001",
                              blk_d, cyc_d, src_d);
    end
    step();
    vectors++;
    if (blk_d !== 1'b1 || cyc_d !== 8'd1) begin
      miscompares++; $display("FAIL t1_sticky got blk=%b cyc=%0d want 1 1", blk_d, cyc_d);
    end
  endtask

  initial begin
    test_reset();
    test_persist();
    test_gap();
    test_sub();
    test_saturate();
    test_clear();
    test_reset_mid();
    test_thresh1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
